// File: rtl/rr_arb2_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb2_pkg
// Shared definitions for the two-input burst-limited arbiter stage.
//   out_state_e    : output register occupancy (EMPTY = 0, FULL = 1)
//   CNT_W          : width of the consecutive-A-grant counter
//   burst_cnt_next : next value of that counter for one cycle's transfers
// ---------------------------------------------------------------------------
package rr_arb2_pkg;

    // Width of the burst counter. It is wide enough for MAX_BURST up to 15.
    localparam int CNT_W = 4;

    // Output register occupancy. The encoding doubles as y_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // The counter tracks how many A words have gone through while B was
    // waiting. Any B transfer, or an A transfer with nobody waiting on B,
    // restarts the count. It saturates at the limit so that B keeps
    // priority until B is actually served.
    function automatic logic [CNT_W-1:0] burst_cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] limit,
        input logic             a_xfer,
        input logic             b_xfer,
        input logic             b_waiting
    );
        if (b_xfer) begin
            return '0;
        end
        if (a_xfer) begin
            if (!b_waiting) begin
                return '0;
            end
            if (cnt >= limit) begin
                return limit;
            end
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_arb2_stage_if.sv
// ---------------------------------------------------------------------------
// rr_arb2_stage_if
// Handshake bundle for rr_arb2_stage: two valid/ready input channels (A, B)
// and one registered valid/ready output channel (y) plus its source flag.
//   a_data/a_valid/a_ready : channel A
//   b_data/b_valid/b_ready : channel B
//   y_data/y_valid/y_ready : merged output
//   sel                    : source of y_data (0 = A, 1 = B)
// Modports:
//   master : the side that sources A/B and consumes y
//   slave  : the arbiter stage itself
// ---------------------------------------------------------------------------
interface rr_arb2_stage_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
    logic             sel;

    modport master (
        output a_data, a_valid, b_data, b_valid, y_ready,
        input  a_ready, b_ready, y_data, y_valid, sel
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, y_ready,
        output a_ready, b_ready, y_data, y_valid, sel
    );

endinterface

// File: rtl/mux_2to1.sv
// ---------------------------------------------------------------------------
// mux_2to1
// Single-bit 2:1 multiplexer.
//   a : selected when s = 0
//   b : selected when s = 1
//   s : select
//   y : output
// ---------------------------------------------------------------------------
module mux_2to1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/rr_arb2_stage.sv
// ---------------------------------------------------------------------------
// rr_arb2_stage
// Merges two valid/ready channels into one registered output. A has priority,
// but after MAX_BURST consecutive A grants while B is waiting, B gets the next
// grant. The output register gives one cycle of latency and still sustains one
// word per cycle, because it reloads on the same edge the old word is consumed.
//   Parameters : WIDTH     - payload width
//                MAX_BURST - A grants in a row allowed while B waits (1..15)
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   bus        : rr_arb2_stage_if.slave (A, B inputs; y output; sel)
// ---------------------------------------------------------------------------
module rr_arb2_stage
    import rr_arb2_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    rr_arb2_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             load;
    logic             grant_a;
    logic             grant_b;
    logic             a_xfer;
    logic             b_xfer;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    // Grant is purely combinational from the valids and the burst count.
    // A wins contention unless it has already used up its burst allowance.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (bus.a_valid && bus.b_valid) begin
            if (cnt_q == BURST_LIMIT) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else if (bus.a_valid) begin
            grant_a = 1'b1;
        end else if (bus.b_valid) begin
            grant_b = 1'b1;
        end
    end

    // The register can take a new word when it is empty or its word is being
    // consumed. Reset gates this directly so the readies drop the moment rst
    // rises, not at the next edge, and no transfer is seen while rst is high.
    assign load   = !rst && ((state_q == ST_EMPTY) || bus.y_ready);
    assign a_xfer = load && grant_a;
    assign b_xfer = load && grant_b;
    assign xfer   = a_xfer || b_xfer;

    assign bus.a_ready = a_xfer;
    assign bus.b_ready = b_xfer;

    // Payload select, one 2:1 mux per bit, steered by the B grant.
    for (genvar i = 0; i < WIDTH; i++) begin : g_data_mux
        mux_2to1 u_mux (
            .a (bus.a_data[i]),
            .b (bus.b_data[i]),
            .s (grant_b),
            .y (mux_data[i])
        );
    end

    // Output register occupancy. A transfer always leaves the register full,
    // which covers both filling from empty and same-edge replacement when
    // full. Without a transfer, a consumed word empties the register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end else if (bus.y_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Payload and source flag only change on a transfer, so a stalled word
    // stays put. y_ready reaches them only through the load qualifier and
    // never as data.
    always_comb begin
        y_data_d = y_data_q;
        sel_d    = sel_q;
        if (xfer) begin
            y_data_d = mux_data;
            sel_d    = grant_b;
        end
    end

    // Burst counter next value.
    always_comb begin
        cnt_d = burst_cnt_next(cnt_q, BURST_LIMIT, a_xfer, b_xfer, bus.b_valid);
    end

    // State register for the output slot and the burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            y_data_q <= '0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            y_data_q <= y_data_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.y_valid = (state_q == ST_FULL);
    assign bus.y_data  = y_data_q;
    assign bus.sel     = sel_q;

endmodule

// File: doc/rr_arb2_stage.md
RR_ARB2_STAGE -- requirements
Module: rr_arb2_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of every channel.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive A grants while B waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a_data  input  WIDTH  channel A payload.
REQ-006 a_valid  input  1  channel A offers a_data.
REQ-007 a_ready  output  1  channel A transfer accepted this cycle.
REQ-008 b_data  input  WIDTH  channel B payload.
REQ-009 b_valid  input  1  channel B offers b_data.
REQ-010 b_ready  output  1  channel B transfer accepted this cycle.
REQ-011 y_data  output  WIDTH  registered winning payload.
REQ-012 y_valid  output  1  y_data holds an unconsumed word.
REQ-013 y_ready  input  1  downstream consumes y_data this cycle.
REQ-014 sel  output  1  registered source of y_data: 0 = A, 1 = B, matching mux select polarity (s=0 picks a).

Function
REQ-015 A transfer on a channel SHALL occur in any cycle where its valid and ready are both 1.
REQ-016 load = (!y_valid || y_ready); a_ready and b_ready SHALL be 0 whenever load = 0.
REQ-017 Grant SHALL be combinational: only A valid -> A; only B valid -> B; neither -> none; both -> A unless cnt == MAX_BURST, then B.
REQ-018 a_ready = load && grant_A; b_ready = load && grant_B; at most one SHALL be 1 in any cycle.
REQ-019 ready SHALL NOT depend on that channel's own valid beyond REQ-017; no combinational path from y_ready to y_data.
REQ-020 Output register states: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-021 EMPTY -> FULL on any input transfer; EMPTY holds otherwise.
REQ-022 FULL with y_ready=1 and an input transfer -> FULL, new word loaded the same edge (zero bubble, throughput 1 word/cycle).
REQ-023 FULL with y_ready=1 and no input transfer -> EMPTY; FULL with y_ready=0 -> FULL, y_data and sel held stable.
REQ-024 On a transfer, y_data SHALL take the granted channel's data and sel the granted channel index on the same edge; latency input-to-output 1 cycle.
REQ-025 cnt (4 bits): +1 on an A transfer with b_valid=1, saturating at MAX_BURST; cleared to 0 on a B transfer or on an A transfer with b_valid=0; otherwise held.
REQ-026 A valid deasserted without a transfer SHALL NOT alter cnt or y_* state.

Reset
REQ-027 While rst=1: y_valid=0, y_data=0, sel=0, cnt=0, a_ready=0, b_ready=0, asynchronously, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard any held output word; no transfer counts in a cycle where rst=1.
REQ-029 First transfer possible on the first rising edge after rst deasserts.

Structure
REQ-030 State encodings (EMPTY=0, FULL=1) and the cnt width constant SHALL live in shared package rr_arb2_pkg.
REQ-031 The data-select path SHALL be built from WIDTH instances of the existing 2:1 mux sub-module mux_2to1, select driven by grant_B.
REQ-032 Grant, cnt and output register logic SHALL be in rr_arb2_stage itself; no other sub-modules.

Verification
REQ-033 Reset: rst=1 with a_valid=b_valid=1 -> a_ready=b_ready=0, y_valid=0, y_data=0x00, sel=0.
REQ-034 Single source: a_valid=1, a_data=0x3C, y_ready=1, b_valid=0 -> next cycle y_valid=1, y_data=0x3C, sel=0; 0x3C,0x3D,0x3E streamed back-to-back appear one per cycle.
REQ-035 Starvation limit: a_valid=b_valid=1, y_ready=1, MAX_BURST=4 -> sel sequence 0,0,0,0,1,0,0,0,0,1 repeating.
REQ-036 Backpressure: FULL with y_data=0x55, y_ready=0 for 3 cycles -> a_ready=b_ready=0, y_data=0x55, sel stable; y_ready=1 and b_valid=1, b_data=0xAA -> next y_data=0xAA, sel=1.
REQ-037 Drain: FULL, y_ready=1, no valid inputs -> y_valid=0 next cycle, cnt unchanged.
REQ-038 Mid-stream reset: rst pulsed asynchronously between edges during REQ-035 traffic -> outputs zero immediately; after release, cnt=0 so A wins first contended grant.
